// File: rtl/score_game_controller_pkg.sv
// Shared definitions for the score game controller: game-state encodings
// and the widths of the status-line address, score and lives mirrors.
package score_game_controller_pkg;

  localparam int DIGIT_ADDR_W = 4;
  localparam int SCORE_W      = 7;
  localparam int LIVES_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SERVE     = 2'd1,
    ST_PLAY      = 2'd2,
    ST_GAME_OVER = 2'd3
  } game_state_e;

endpackage

// File: rtl/score_game_controller_strobe_queue.sv
// Saturating 2-bit pending counter that drains as one-cycle strobes with at
// least one low cycle between consecutive strobes; flush discards everything.
module score_game_controller_strobe_queue
  import score_game_controller_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic flush,
  output logic strobe
);

  logic [1:0] pend_q, pend_d, pend_in;
  logic       strobe_q, strobe_d;

  always_comb begin
    pend_in  = pend_q;
    pend_d   = pend_q;
    strobe_d = 1'b0;
    if (push && (pend_q != 2'd3)) begin
      pend_in = pend_q + 2'd1;
    end
    pend_d = pend_in;
    // A fresh event can fire on the very next cycle when the line is idle.
    if (flush) begin
      pend_d = 2'd0;
    end else if (!strobe_q && (pend_in != 2'd0)) begin
      strobe_d = 1'b1;
      pend_d   = pend_in - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q   <= 2'd0;
      strobe_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      strobe_q <= strobe_d;
    end
  end

  assign strobe = strobe_q;

endmodule

// File: rtl/score_game_controller.sv
// Game-flow sequencer between the ball logic and the score register, plus the
// status-line digit address scanner.
//   state        | meaning
//   ST_IDLE      | waiting for start after reset
//   ST_SERVE     | counting frame ticks before the ball is released
//   ST_PLAY      | ball live; hits score, misses cost a life
//   ST_GAME_OVER | lives exhausted; waiting for start
module score_game_controller
  import score_game_controller_pkg::*;
#(
  parameter int NUM_LIVES    = 5,
  parameter int MAX_SCORE    = 99,
  parameter int SERVE_FRAMES = 60,
  parameter int SCAN_DIV     = 16,
  parameter int NUM_DIGITS   = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    frame_tick,
  input  logic                    hit_event,
  input  logic                    miss_event,
  output logic                    score_strobe,
  output logic                    life_strobe,
  output logic                    score_clear,
  output logic [DIGIT_ADDR_W-1:0] digit_addr,
  output logic [LIVES_W-1:0]      lives_left,
  output logic [SCORE_W-1:0]      score_value,
  output logic [1:0]              game_state,
  output logic                    ball_enable
);

  localparam int SERVE_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam int SCAN_W  = $clog2(SCAN_DIV);

  game_state_e               state_q, state_d;
  logic [SERVE_W-1:0]        serve_cnt_q, serve_cnt_d;
  logic [LIVES_W-1:0]        lives_q, lives_d;
  logic [SCORE_W-1:0]        score_q, score_d;
  logic                      clear_q, clear_d;
  logic [SCAN_W-1:0]         scan_cnt_q, scan_cnt_d;
  logic [DIGIT_ADDR_W-1:0]   digit_addr_q, digit_addr_d;
  logic                      score_push, life_push;

  always_comb begin
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    lives_d     = lives_q;
    score_d     = score_q;
    clear_d     = 1'b0;
    score_push  = 1'b0;
    life_push   = 1'b0;
    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (start) begin
          state_d     = ST_SERVE;
          clear_d     = 1'b1;
          lives_d     = LIVES_W'(NUM_LIVES);
          score_d     = '0;
          serve_cnt_d = '0;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (serve_cnt_q == SERVE_W'(SERVE_FRAMES - 1)) begin
            state_d     = ST_PLAY;
            serve_cnt_d = '0;
          end else begin
            serve_cnt_d = serve_cnt_q + 1'b1;
          end
        end
      end
      ST_PLAY: begin
        if (hit_event && (score_q < SCORE_W'(MAX_SCORE))) begin
          score_push = 1'b1;
          score_d    = score_q + 1'b1;
        end
        // Miss wins the transition even when a hit lands in the same cycle.
        if (miss_event) begin
          life_push   = 1'b1;
          lives_d     = lives_q - 1'b1;
          serve_cnt_d = '0;
          state_d     = (lives_q == LIVES_W'(1)) ? ST_GAME_OVER : ST_SERVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    scan_cnt_d   = scan_cnt_q + 1'b1;
    digit_addr_d = digit_addr_q;
    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d   = '0;
      digit_addr_d = (digit_addr_q == DIGIT_ADDR_W'(NUM_DIGITS - 1)) ? '0 : digit_addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      serve_cnt_q  <= '0;
      lives_q      <= LIVES_W'(NUM_LIVES);
      score_q      <= '0;
      clear_q      <= 1'b0;
      scan_cnt_q   <= '0;
      digit_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      serve_cnt_q  <= serve_cnt_d;
      lives_q      <= lives_d;
      score_q      <= score_d;
      clear_q      <= clear_d;
      scan_cnt_q   <= scan_cnt_d;
      digit_addr_q <= digit_addr_d;
    end
  end

  // Queues are flushed on the same edge clear_q rises, so strobes are low while it is high.
  score_game_controller_strobe_queue u_score_q (
    .clk    (clk),
    .reset  (reset),
    .push   (score_push),
    .flush  (clear_d),
    .strobe (score_strobe)
  );

  score_game_controller_strobe_queue u_life_q (
    .clk    (clk),
    .reset  (reset),
    .push   (life_push),
    .flush  (clear_d),
    .strobe (life_strobe)
  );

  assign score_clear = clear_q;
  assign digit_addr  = digit_addr_q;
  assign lives_left  = lives_q;
  assign score_value = score_q;
  assign game_state  = state_q;
  assign ball_enable = (state_q == ST_PLAY);

endmodule

// File: tb/tb_score_game_controller.sv
// Self-checking bench for score_game_controller: per-cycle reference model,
// a vector table for the PLAY strobe pattern, and directed corner sequences.
module tb_score_game_controller;

  localparam int NUM_LIVES    = 5;
  localparam int MAX_SCORE    = 99;
  localparam int SERVE_FRAMES = 60;
  localparam int SCAN_DIV     = 16;
  localparam int NUM_DIGITS   = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0, frame_tick = 1'b0, hit_event = 1'b0, miss_event = 1'b0;
  logic       score_strobe, life_strobe, score_clear, ball_enable;
  logic [3:0] digit_addr;
  logic [2:0] lives_left;
  logic [6:0] score_value;
  logic [1:0] game_state;

  int n_checks = 0;
  int n_fail   = 0;

  score_game_controller #(
    .NUM_LIVES(NUM_LIVES), .MAX_SCORE(MAX_SCORE), .SERVE_FRAMES(SERVE_FRAMES),
    .SCAN_DIV(SCAN_DIV), .NUM_DIGITS(NUM_DIGITS)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
    .hit_event(hit_event), .miss_event(miss_event),
    .score_strobe(score_strobe), .life_strobe(life_strobe), .score_clear(score_clear),
    .digit_addr(digit_addr), .lives_left(lives_left), .score_value(score_value),
    .game_state(game_state), .ball_enable(ball_enable)
  );

  always #5 clk = ~clk;

  // Reference model: game rules in plain integers; states 0 idle,1 serve,2 play,3 over.
  int m_state, m_lives, m_score, m_ticks, m_pend_s, m_pend_l, m_cycles;
  bit m_sstb, m_lstb, m_clr;

  function automatic void model_reset();
    m_state = 0; m_lives = NUM_LIVES; m_score = 0; m_ticks = 0;
    m_pend_s = 0; m_pend_l = 0; m_sstb = 0; m_lstb = 0; m_clr = 0; m_cycles = 0;
  endfunction

  function automatic void model_step(bit st, bit tk, bit h, bit ms);
    bit clr = 0;
    int add_s = 0;
    int add_l = 0;
    m_cycles++;
    if (m_state == 0 || m_state == 3) begin
      if (st) begin
        clr = 1; m_state = 1; m_lives = NUM_LIVES; m_score = 0; m_ticks = 0;
      end
    end else if (m_state == 1) begin
      if (tk) begin
        m_ticks++;
        if (m_ticks == SERVE_FRAMES) begin m_state = 2; m_ticks = 0; end
      end
    end else begin
      if (h && m_score < MAX_SCORE) begin m_score++; add_s = 1; end
      if (ms) begin
        add_l = 1; m_lives--; m_ticks = 0;
        m_state = (m_lives == 0) ? 3 : 1;
      end
    end
    m_clr = clr;
    m_pend_s = (m_pend_s + add_s > 3) ? 3 : m_pend_s + add_s;
    if (clr) begin m_pend_s = 0; m_sstb = 0; end
    else if (!m_sstb && m_pend_s > 0) begin m_sstb = 1; m_pend_s--; end
    else m_sstb = 0;
    m_pend_l = (m_pend_l + add_l > 3) ? 3 : m_pend_l + add_l;
    if (clr) begin m_pend_l = 0; m_lstb = 0; end
    else if (!m_lstb && m_pend_l > 0) begin m_lstb = 1; m_pend_l--; end
    else m_lstb = 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail < 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("game_state", int'(game_state), m_state);
    chk("score_strobe", int'(score_strobe), int'(m_sstb));
    chk("life_strobe", int'(life_strobe), int'(m_lstb));
    chk("score_clear", int'(score_clear), int'(m_clr));
    chk("ball_enable", int'(ball_enable), (m_state == 2) ? 1 : 0);
    chk("lives_left", int'(lives_left), m_lives);
    chk("score_value", int'(score_value), m_score);
    chk("digit_addr", int'(digit_addr), (m_cycles / SCAN_DIV) % NUM_DIGITS);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (reset) model_step(start, frame_tick, hit_event, miss_event);
    else model_reset();
    #1;
    check_all();
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic serve_to_play();
    for (int i = 1; i <= SERVE_FRAMES; i++) begin
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc();
    end
    chk("serve_to_play_state", int'(game_state), 2);
  endtask

  typedef struct {
    logic st, tk, h, ms;
    int   state;
    logic sstb, lstb;
    int   score, lives;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int clr_cnt;
    int stb_cnt;

    // inputs st,tk,h,ms | expected after edge: state,sstb,lstb,score,lives
    tbl[0] = '{0, 0, 1, 0, 2, 1, 0, 1, 5};
    tbl[1] = '{0, 0, 1, 0, 2, 0, 0, 2, 5};
    tbl[2] = '{0, 0, 1, 0, 2, 1, 0, 3, 5};
    tbl[3] = '{0, 0, 0, 0, 2, 0, 0, 3, 5};
    tbl[4] = '{0, 0, 0, 0, 2, 1, 0, 3, 5};
    tbl[5] = '{0, 0, 0, 0, 2, 0, 0, 3, 5};
    tbl[6] = '{0, 0, 1, 1, 1, 1, 1, 4, 4};
    tbl[7] = '{0, 0, 1, 0, 1, 0, 0, 4, 4};
    tbl[8] = '{0, 0, 0, 1, 1, 0, 0, 4, 4};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_lives", int'(lives_left), NUM_LIVES);
    reset = 1'b1;

    // Scan divider: address steps every SCAN_DIV clocks and wraps 9 -> 0.
    for (int i = 1; i <= 170; i++) begin
      cyc();
      if (i == 15)  chk("scan_hold", int'(digit_addr), 0);
      if (i == 16)  chk("scan_step", int'(digit_addr), 1);
      if (i == 159) chk("scan_last", int'(digit_addr), 9);
      if (i == 160) chk("scan_wrap", int'(digit_addr), 0);
    end

    // Start and serve: PLAY on the cycle after the 60th tick, one clear pulse.
    pulse_start();
    chk("start_clear", int'(score_clear), 1);
    chk("start_state", int'(game_state), 1);
    clr_cnt = 1;
    for (int i = 1; i <= SERVE_FRAMES; i++) begin
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
      clr_cnt += int'(score_clear);
      if (i == SERVE_FRAMES) begin
        chk("play_after_60", int'(game_state), 2);
        chk("ball_enable_play", int'(ball_enable), 1);
      end else begin
        chk("serve_hold", int'(game_state), 1);
      end
      cyc();
      clr_cnt += int'(score_clear);
    end
    chk("clear_once", clr_cnt, 1);

    // Table: back-to-back hits, then hit+miss in one cycle.
    for (int i = 0; i < 9; i++) begin
      start = tbl[i].st; frame_tick = tbl[i].tk; hit_event = tbl[i].h; miss_event = tbl[i].ms;
      cyc();
      chk($sformatf("vec%0d_state", i), int'(game_state), tbl[i].state);
      chk($sformatf("vec%0d_sstb", i), int'(score_strobe), int'(tbl[i].sstb));
      chk($sformatf("vec%0d_lstb", i), int'(life_strobe), int'(tbl[i].lstb));
      chk($sformatf("vec%0d_score", i), int'(score_value), tbl[i].score);
      chk($sformatf("vec%0d_lives", i), int'(lives_left), tbl[i].lives);
    end
    start = 0; frame_tick = 0; hit_event = 0; miss_event = 0;

    // Reset mid-PLAY with two score strobes pending.
    serve_to_play();
    hit_event = 1'b1; repeat (4) cyc(); hit_event = 1'b0;
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_state", int'(game_state), 0);
    chk("rst_sstb", int'(score_strobe), 0);
    repeat (3) cyc();
    reset = 1'b1;
    stb_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      stb_cnt += int'(score_strobe) + int'(life_strobe);
    end
    chk("no_strobe_after_reset", stb_cnt, 0);

    // Five misses across serves, then restart from GAME_OVER.
    pulse_start();
    for (int k = 0; k < NUM_LIVES; k++) begin
      serve_to_play();
      miss_event = 1'b1; cyc(); miss_event = 1'b0;
    end
    chk("go_state", int'(game_state), 3);
    chk("go_lives", int'(lives_left), 0);
    chk("go_ball", int'(ball_enable), 0);
    repeat (3) cyc();
    pulse_start();
    chk("restart_lives", int'(lives_left), NUM_LIVES);
    chk("restart_score", int'(score_value), 0);
    chk("restart_state", int'(game_state), 1);

    // Score saturation: a hit at MAX_SCORE issues no strobe.
    serve_to_play();
    hit_event = 1'b1; repeat (MAX_SCORE + 1) cyc(); hit_event = 1'b0;
    chk("score_sat", int'(score_value), MAX_SCORE);
    repeat (10) cyc();
    hit_event = 1'b1; cyc(); hit_event = 1'b0;
    chk("sat_no_strobe", int'(score_strobe), 0);
    cyc();
    chk("sat_no_strobe2", int'(score_strobe), 0);
    chk("sat_score_hold", int'(score_value), MAX_SCORE);

    // Randomized play against the model.
    for (int i = 0; i < 4000; i++) begin
      start      = ($urandom_range(0, 40) == 0);
      frame_tick = ($urandom_range(0, 1) == 0);
      hit_event  = ($urandom_range(0, 3) == 0);
      miss_event = ($urandom_range(0, 15) == 0);
      cyc();
    end
    start = 0; frame_tick = 0; hit_event = 0; miss_event = 0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
